cdb_arbiter: RTL and testbench

Round-robin arbiter that shares the single common data bus (CDB) between the Tomasulo functional-unit reservation stations (ALU, MUL, DIV, load/store). Each station presents a finished result (tag, value, ICC flags). The block grants at most one station per cycle and drives the registered CDB broadcast that all reservation stations and the register file snoop. Completion ordering, tag capture and Y/ICC forwarding downstream depend on this block's fairness and one-broadcast-per-cycle guarantee.

---
 rtl/tomasulo_pkg.sv | 21 ++
 rtl/rr_picker.sv | 32 +++
 rtl/cdb_arbiter.sv | 97 +++++++++
 tb/tb_cdb_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo constants: CDB widths, the reserved invalid tag, ICC bit
// positions and reservation-station indices.
package tomasulo_pkg;

  localparam int CDB_TAG_W  = 5;
  localparam int CDB_DATA_W = 32;

  localparam logic [CDB_TAG_W-1:0] INVALID_TAG = 5'h1F;

  // ICC flags travel as {c,v,z,n}
  localparam int ICC_N = 0;
  localparam int ICC_Z = 1;
  localparam int ICC_V = 2;
  localparam int ICC_C = 3;

  localparam int RS_ALU = 0;
  localparam int RS_MUL = 1;
  localparam int RS_DIV = 2;
  localparam int RS_LS  = 3;

endpackage

// File: rtl/rr_picker.sv
// Combinational wrap-around first-one search starting at ptr; returns one-hot
// grant, winner index and whether any request was found.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (!any && req[pos]) begin
        any        = 1'b1;
        idx        = IW'(pos);
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants one finished station per cycle and drives
// the registered common-data-bus broadcast snooped by stations and regfile.
module cdb_arbiter import tomasulo_pkg::*; #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    in_req,
  input  logic [N_REQ*TAG_W-1:0]  in_tag,
  input  logic [N_REQ*DATA_W-1:0] in_val,
  input  logic [N_REQ*4-1:0]  in_icc,
  input  logic                in_flush,
  output logic [N_REQ-1:0]    out_grant,
  output logic                out_CDB_broadcast,
  output logic [TAG_W-1:0]    out_CDB_tag,
  output logic [DATA_W-1:0]   out_CDB_val,
  output logic [3:0]          out_ICC_flags,
  output logic                out_tag_err
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [TAG_W-1:0] INV_TAG = {TAG_W{1'b1}};

  logic [IW-1:0]     ptr;
  logic [N_REQ-1:0]  pick_grant;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              xfer_p0;
  logic [TAG_W-1:0]  win_tag_p0;
  logic [DATA_W-1:0] win_val_p0;
  logic [3:0]        win_icc_p0;
  logic [IW-1:0]     ptr_next;

  logic              bcast_vld_p1;
  logic [TAG_W-1:0]  bcast_tag_p1;
  logic [DATA_W-1:0] bcast_val_p1;
  logic [3:0]        bcast_icc_p1;
  logic              tag_err_p1;

  rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
    .req   (in_req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Stage p0: combinational grant and winner mux; flush and reset suppress it
  always_comb begin
    xfer_p0    = pick_any && rst_n && !in_flush;
    out_grant  = xfer_p0 ? pick_grant : '0;
    win_tag_p0 = in_tag[pick_idx*TAG_W +: TAG_W];
    win_val_p0 = in_val[pick_idx*DATA_W +: DATA_W];
    win_icc_p0 = in_icc[pick_idx*4 +: 4];
    ptr_next   = (pick_idx == IW'(N_REQ-1)) ? '0 : pick_idx + IW'(1);
  end

  // Stage p1: registered broadcast; an invalid tag is consumed without broadcast
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr          <= '0;
      bcast_vld_p1 <= 1'b0;
      bcast_tag_p1 <= INV_TAG;
      bcast_val_p1 <= '0;
      bcast_icc_p1 <= '0;
      tag_err_p1   <= 1'b0;
    end else if (in_flush) begin
      ptr          <= '0;
      bcast_vld_p1 <= 1'b0;
      tag_err_p1   <= 1'b0;
    end else if (xfer_p0) begin
      ptr <= ptr_next;
      if (win_tag_p0 == INV_TAG) begin
        bcast_vld_p1 <= 1'b0;
        tag_err_p1   <= 1'b1;
      end else begin
        bcast_vld_p1 <= 1'b1;
        bcast_tag_p1 <= win_tag_p0;
        bcast_val_p1 <= win_val_p0;
        bcast_icc_p1 <= win_icc_p0;
        tag_err_p1   <= 1'b0;
      end
    end else begin
      bcast_vld_p1 <= 1'b0;
      tag_err_p1   <= 1'b0;
    end
  end

  assign out_CDB_broadcast = bcast_vld_p1;
  assign out_CDB_tag       = bcast_tag_p1;
  assign out_CDB_val       = bcast_val_p1;
  assign out_ICC_flags     = bcast_icc_p1;
  assign out_tag_err       = tag_err_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter with hand-written reset,
// single-request and reset-mid-operation sequences.
module tb_cdb_arbiter;
  import tomasulo_pkg::*;

  localparam int N = 4;
  localparam int TW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      in_req;
  logic [N*TW-1:0]   in_tag;
  logic [N*DW-1:0]   in_val;
  logic [N*4-1:0]    in_icc;
  logic              in_flush;
  logic [N-1:0]      out_grant;
  logic              out_CDB_broadcast;
  logic [TW-1:0]     out_CDB_tag;
  logic [DW-1:0]     out_CDB_val;
  logic [3:0]        out_ICC_flags;
  logic              out_tag_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_req            (in_req),
    .in_tag            (in_tag),
    .in_val            (in_val),
    .in_icc            (in_icc),
    .in_flush          (in_flush),
    .out_grant         (out_grant),
    .out_CDB_broadcast (out_CDB_broadcast),
    .out_CDB_tag       (out_CDB_tag),
    .out_CDB_val       (out_CDB_val),
    .out_ICC_flags     (out_ICC_flags),
    .out_tag_err       (out_tag_err)
  );

  always #5 clk = ~clk;

  function automatic logic [TW-1:0] tag_of(int i);
    return TW'(i + 4);
  endfunction
  function automatic logic [DW-1:0] val_of(int i);
    return 32'hA000_0000 | DW'(i);
  endfunction
  function automatic logic [3:0] icc_of(int i);
    return 4'(i + 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // inv_mask marks stations whose tag is replaced by INVALID_TAG
  task automatic drive(input logic [N-1:0] req, input logic flush, input logic [N-1:0] inv_mask);
    in_req   = req;
    in_flush = flush;
    for (int i = 0; i < N; i++) begin
      in_tag[i*TW +: TW] = inv_mask[i] ? INVALID_TAG : tag_of(i);
      in_val[i*DW +: DW] = val_of(i);
      in_icc[i*4 +: 4]   = icc_of(i);
    end
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         flush;
    logic [N-1:0] inv;
    logic [N-1:0] exp_grant;
    logic         exp_bcast;
    int           exp_src;
    logic         exp_err;
    logic [1:0]   exp_ptr;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b1, 0, 1'b0, 2'd1};
    vecs[1]  = '{4'b1111, 1'b0, 4'b0000, 4'b0010, 1'b1, 1, 1'b0, 2'd2};
    vecs[2]  = '{4'b1111, 1'b0, 4'b0000, 4'b0100, 1'b1, 2, 1'b0, 2'd3};
    vecs[3]  = '{4'b1111, 1'b0, 4'b0000, 4'b1000, 1'b1, 3, 1'b0, 2'd0};
    vecs[4]  = '{4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b1, 0, 1'b0, 2'd1};
    vecs[5]  = '{4'b1111, 1'b0, 4'b0000, 4'b0010, 1'b1, 1, 1'b0, 2'd2};
    vecs[6]  = '{4'b1111, 1'b0, 4'b0000, 4'b0100, 1'b1, 2, 1'b0, 2'd3};
    vecs[7]  = '{4'b1111, 1'b0, 4'b0000, 4'b1000, 1'b1, 3, 1'b0, 2'd0};
    vecs[8]  = '{4'b0100, 1'b0, 4'b0000, 4'b0100, 1'b1, 2, 1'b0, 2'd3};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2, 1'b0, 2'd3};
    vecs[10] = '{4'b0011, 1'b0, 4'b0000, 4'b0001, 1'b1, 0, 1'b0, 2'd1};
    vecs[11] = '{4'b0010, 1'b0, 4'b0000, 4'b0010, 1'b1, 1, 1'b0, 2'd2};
    vecs[12] = '{4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b0, 1, 1'b1, 2'd2};
    vecs[13] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1, 1'b0, 2'd2};
    vecs[14] = '{4'b1111, 1'b0, 4'b0000, 4'b0100, 1'b1, 2, 1'b0, 2'd3};
    vecs[15] = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 2, 1'b0, 2'd0};
    vecs[16] = '{4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b1, 0, 1'b0, 2'd1};

    // Reset held two cycles with every station requesting
    rst_n = 1'b0;
    drive(4'b1111, 1'b0, 4'b0000);
    #1;
    check("reset_grant", 64'(out_grant), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_grant_held", 64'(out_grant), 64'h0);
    check("reset_bcast", 64'(out_CDB_broadcast), 64'h0);
    check("reset_tag", 64'(out_CDB_tag), 64'h1F);
    check("reset_val", 64'(out_CDB_val), 64'h0);
    check("reset_icc", 64'(out_ICC_flags), 64'h0);
    check("reset_err", 64'(out_tag_err), 64'h0);
    check("reset_ptr", 64'(dut.ptr), 64'h0);

    for (int v = 0; v < 17; v++) begin
      @(negedge clk);
      rst_n = 1'b1;
      drive(vecs[v].req, vecs[v].flush, vecs[v].inv);
      #1;
      check($sformatf("v%0d_grant", v), 64'(out_grant), 64'(vecs[v].exp_grant));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_bcast", v), 64'(out_CDB_broadcast), 64'(vecs[v].exp_bcast));
      check($sformatf("v%0d_tag", v), 64'(out_CDB_tag), 64'(tag_of(vecs[v].exp_src)));
      check($sformatf("v%0d_val", v), 64'(out_CDB_val), 64'(val_of(vecs[v].exp_src)));
      check($sformatf("v%0d_icc", v), 64'(out_ICC_flags), 64'(icc_of(vecs[v].exp_src)));
      check($sformatf("v%0d_err", v), 64'(out_tag_err), 64'(vecs[v].exp_err));
      check($sformatf("v%0d_ptr", v), 64'(dut.ptr), 64'(vecs[v].exp_ptr));
    end

    // Single request from the divider station with specific payload
    @(negedge clk);
    drive(4'b0100, 1'b0, 4'b0000);
    in_tag[RS_DIV*TW +: TW] = 5'd3;
    in_val[RS_DIV*DW +: DW] = 32'hDEAD_BEEF;
    in_icc[RS_DIV*4 +: 4]   = 4'b0010;
    #1;
    check("single_grant", 64'(out_grant), 64'h4);
    @(posedge clk);
    #1;
    check("single_bcast", 64'(out_CDB_broadcast), 64'h1);
    check("single_tag", 64'(out_CDB_tag), 64'h3);
    check("single_val", 64'(out_CDB_val), 64'hDEAD_BEEF);
    check("single_icc", 64'(out_ICC_flags), 64'h2);
    @(negedge clk);
    drive(4'b0000, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    check("single_bcast_drop", 64'(out_CDB_broadcast), 64'h0);
    check("single_tag_hold", 64'(out_CDB_tag), 64'h3);

    // Build a pending broadcast, then reset mid-operation discards it
    @(negedge clk);
    drive(4'b1111, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    check("mid_pre_bcast", 64'(out_CDB_broadcast), 64'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", 64'(out_grant), 64'h0);
    @(posedge clk);
    #1;
    check("mid_rst_bcast", 64'(out_CDB_broadcast), 64'h0);
    check("mid_rst_tag", 64'(out_CDB_tag), 64'h1F);
    check("mid_rst_ptr", 64'(dut.ptr), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_first_grant", 64'(out_grant), 64'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
